// File: rtl/semaforo_fsm.sv
// -----------------------------------------------------------------------------
// semaforo_fsm
//   Three-state Moore traffic-light controller (green / yellow / red).
//   Green leaves on a car request. Yellow is held for a fixed number of
//   cycles. Red leaves on an external timeout strobe.
//
//   Optional feature macro: SEMAFORO_INT_TIMER_EN
//     When defined, an internal 16-bit red-phase timer also ends the red
//     phase after VERMELHO_CYCLES cycles. TIMEOUT still forces an early exit.
//
// Parameters
//   AMARELO_CYCLES  : yellow hold length in cycles (1..255)
//   VERMELHO_CYCLES : red length for the internal timer (1..65535)
//
// Ports
//   clk      in   system clock, rising edge
//   res      in   asynchronous active-low reset
//   CAR      in   car-present request
//   TIMEOUT  in   red-phase-expired strobe
//   VERDE    out  green lamp
//   AMARELO  out  yellow lamp
//   VERMELHO out  red lamp
//   ESTADO   out  [1:0] current state code (debug)
// -----------------------------------------------------------------------------
module semaforo_fsm #(
  parameter int unsigned AMARELO_CYCLES  = 1,
  parameter int unsigned VERMELHO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic       CAR,
  input  logic       TIMEOUT,
  output logic       VERDE,
  output logic       AMARELO,
  output logic       VERMELHO,
  output logic [1:0] ESTADO
);

  typedef enum logic [1:0] {
    ST_VERDE    = 2'b00,
    ST_AMARELO  = 2'b01,
    ST_VERMELHO = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  // Refuse to build with out-of-range timing parameters.
  if ((AMARELO_CYCLES < 32'd1) || (AMARELO_CYCLES > 32'd255)) begin : g_bad_amarelo
    $error("semaforo_fsm: AMARELO_CYCLES out of range 1..255");
  end
  if ((VERMELHO_CYCLES < 32'd1) || (VERMELHO_CYCLES > 32'd65535)) begin : g_bad_vermelho
    $error("semaforo_fsm: VERMELHO_CYCLES out of range 1..65535");
  end

  localparam logic [7:0] AMARELO_LAST = 8'(AMARELO_CYCLES - 32'd1);

  state_t     state_r;
  state_t     state_s;
  logic [7:0] amarelo_cnt_r;
  logic [7:0] amarelo_cnt_s;
  logic       red_exit_s;

`ifdef SEMAFORO_INT_TIMER_EN
  localparam logic [15:0] VERMELHO_LAST = 16'(VERMELHO_CYCLES - 32'd1);

  logic [15:0] vermelho_cnt_r;
  logic [15:0] vermelho_cnt_s;

  // Red-phase timer: zero outside red, so it is already clear on entry.
  always_comb begin
    vermelho_cnt_s = 16'd0;
    if (state_r == ST_VERMELHO) begin
      vermelho_cnt_s = vermelho_cnt_r + 16'd1;
    end else begin
      vermelho_cnt_s = 16'd0;
    end
  end

  // Red-phase timer register.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      vermelho_cnt_r <= 16'd0;
    end else begin
      vermelho_cnt_r <= vermelho_cnt_s;
    end
  end

  assign red_exit_s = TIMEOUT || (vermelho_cnt_r == VERMELHO_LAST);
`else
  assign red_exit_s = TIMEOUT;
`endif

  // Next-state and yellow-counter logic; counter is zero outside yellow.
  always_comb begin
    state_s       = state_r;
    amarelo_cnt_s = 8'd0;
    case (state_r)
      ST_VERDE: begin
        if (CAR) begin
          state_s = ST_AMARELO;
        end else begin
          state_s = ST_VERDE;
        end
      end
      ST_AMARELO: begin
        if (amarelo_cnt_r == AMARELO_LAST) begin
          state_s       = ST_VERMELHO;
          amarelo_cnt_s = 8'd0;
        end else begin
          state_s       = ST_AMARELO;
          amarelo_cnt_s = amarelo_cnt_r + 8'd1;
        end
      end
      ST_VERMELHO: begin
        if (red_exit_s) begin
          state_s = ST_VERDE;
        end else begin
          state_s = ST_VERMELHO;
        end
      end
      default: begin
        state_s = ST_VERDE;
      end
    endcase
  end

  // State and yellow-counter registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_r       <= ST_VERDE;
      amarelo_cnt_r <= 8'd0;
    end else begin
      state_r       <= state_s;
      amarelo_cnt_r <= amarelo_cnt_s;
    end
  end

  // Lamp decode from the state register only; the illegal code shows green
  // so the lamps stay one-hot until the recovery edge.
  always_comb begin
    VERDE    = 1'b0;
    AMARELO  = 1'b0;
    VERMELHO = 1'b0;
    case (state_r)
      ST_VERDE:    VERDE    = 1'b1;
      ST_AMARELO:  AMARELO  = 1'b1;
      ST_VERMELHO: VERMELHO = 1'b1;
      default:     VERDE    = 1'b1;
    endcase
  end

  assign ESTADO = state_r;

endmodule

// File: tb/tb_semaforo_fsm.sv
module tb_semaforo_fsm;

  localparam logic [1:0] S_VD = 2'b00;
  localparam logic [1:0] S_AM = 2'b01;
  localparam logic [1:0] S_VM = 2'b10;

  logic       clk;
  logic       res;
  logic       car_a, timeout_a, car_b, timeout_b;
  logic       verde_a, amarelo_a, vermelho_a;
  logic       verde_b, amarelo_b, vermelho_b;
  logic [1:0] estado_a, estado_b;

  int n_cmp;
  int n_err;

  semaforo_fsm #(.AMARELO_CYCLES(1), .VERMELHO_CYCLES(16)) dut_a (
    .clk(clk), .res(res), .CAR(car_a), .TIMEOUT(timeout_a),
    .VERDE(verde_a), .AMARELO(amarelo_a), .VERMELHO(vermelho_a), .ESTADO(estado_a)
  );

  semaforo_fsm #(.AMARELO_CYCLES(3), .VERMELHO_CYCLES(4)) dut_b (
    .clk(clk), .res(res), .CAR(car_b), .TIMEOUT(timeout_b),
    .VERDE(verde_b), .AMARELO(amarelo_b), .VERMELHO(vermelho_b), .ESTADO(estado_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string tag, logic [4:0] obs, logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed {V,A,R,ESTADO}=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] model(logic [1:0] st);
    case (st)
      S_VD:    model = {3'b100, st};
      S_AM:    model = {3'b010, st};
      S_VM:    model = {3'b001, st};
      default: model = 5'b00000;
    endcase
  endfunction

  task automatic chk_a(string tag, logic [1:0] st);
    cmp(tag, {verde_a, amarelo_a, vermelho_a, estado_a}, model(st));
  endtask

  task automatic chk_b(string tag, logic [1:0] st);
    cmp(tag, {verde_b, amarelo_b, vermelho_b, estado_b}, model(st));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    res = 1'b0; car_a = 1'b0; timeout_a = 1'b0; car_b = 1'b0; timeout_b = 1'b0;

    // Reset: before first edge and after an edge while held
    #1;  chk_a("rst_pre_edge", S_VD); chk_b("rst_pre_edge_b", S_VD);
    #11; chk_a("rst_held", S_VD);
    res = 1'b1;

    // Green hold, then exit on CAR
    for (int i = 0; i < 3; i++) begin tick(); chk_a("green_hold", S_VD); end
    car_a = 1'b1; tick(); chk_a("green_to_yellow", S_AM);
    car_a = 1'b0; tick(); chk_a("yellow_to_red", S_VM);

    // Red hold with CAR toggling
    for (int i = 0; i < 4; i++) begin
      car_a = ~car_a; tick(); chk_a("red_hold_car_toggle", S_VM);
    end
    car_a = 1'b0;
    timeout_a = 1'b1; tick(); chk_a("red_to_green", S_VD);
    tick(); chk_a("timeout_high_in_green", S_VD);
    tick(); chk_a("timeout_ignored_green", S_VD);
    timeout_a = 1'b0;

    // CAR held high: one yellow pass, stop in red
    car_a = 1'b1;
    tick(); chk_a("car_held_yellow", S_AM);
    tick(); chk_a("car_held_red", S_VM);
    tick(); chk_a("car_held_stay_red", S_VM);

    // CAR and TIMEOUT together in red: exit only, CAR acted on next edge
    timeout_a = 1'b1;
    tick(); chk_a("both_in_red", S_VD);
    timeout_a = 1'b0;
    tick(); chk_a("car_after_red_exit", S_AM);
    car_a = 1'b0;
    tick(); chk_a("second_red", S_VM);
    timeout_a = 1'b1; tick(); chk_a("second_exit", S_VD);
    timeout_a = 1'b0;

    // Asynchronous reset while yellow
    car_a = 1'b1; tick(); chk_a("pre_reset_yellow", S_AM);
    car_a = 1'b0;
    #3; res = 1'b0;
    #1; chk_a("async_reset_mid_yellow", S_VD);
    #2; res = 1'b1;
    tick(); chk_a("after_reset_green", S_VD);
    car_a = 1'b1; tick(); chk_a("restart_yellow", S_AM);
    car_a = 1'b0; tick(); chk_a("restart_red", S_VM);
    timeout_a = 1'b1; tick(); chk_a("restart_exit", S_VD);
    timeout_a = 1'b0;

    // AMARELO_CYCLES=3 instance: yellow for exactly 3 cycles
    chk_b("b_idle_green", S_VD);
    car_b = 1'b1; tick(); chk_b("b_yellow_1", S_AM);
    car_b = 1'b0;
    tick(); chk_b("b_yellow_2", S_AM);
    tick(); chk_b("b_yellow_3", S_AM);
    tick(); chk_b("b_red_1", S_VM);
    for (int i = 0; i < 3; i++) begin tick(); chk_b("b_red_hold", S_VM); end
`ifdef SEMAFORO_INT_TIMER_EN
    tick(); chk_b("b_int_timer_exit", S_VD);
`else
    tick(); chk_b("b_red_no_timer", S_VM);
    timeout_b = 1'b1; tick(); chk_b("b_timeout_exit", S_VD);
    timeout_b = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/semaforo_fsm.md
Name: semaforo_fsm

Overview:
- Three-state Moore traffic-light controller: green, yellow, red.
- Green leaves on a car request, yellow lasts a fixed number of cycles, red leaves on an external timeout.
- Sits between the vehicle sensor / red-phase timer and the lamp drivers.
- Outputs are exactly one-hot at all times.

Parameters:
- AMARELO_CYCLES, 1, number of clock cycles the yellow state is held (legal range 1..255).
- VERMELHO_CYCLES, 16, red-phase length in cycles for the internal timer (used only with SEMAFORO_INT_TIMER_EN, legal range 1..65535).

Ports:
- clk  input  1  system clock, rising-edge active.
- res  input  1  asynchronous active-low reset.
- CAR  input  1  car-present request, sampled on rising clk.
- TIMEOUT  input  1  red-phase-expired strobe, sampled on rising clk.
- VERDE  output  1  green lamp.
- AMARELO  output  1  yellow lamp.
- VERMELHO  output  1  red lamp.
- ESTADO  output  2  current state code, for debug.

Behaviour:
- Clocking and reset:
  - Single clock domain, clk.
  - res is asynchronous and active-low. While res=0, the state is forced to VERDE immediately, independent of clk.
  - Release of res is synchronous to the next clk edge.
- State encoding (ESTADO):
  - VERDE = 2'b00
  - AMARELO = 2'b01
  - VERMELHO = 2'b10
  - 2'b11 is illegal.
- Reset values: VERDE=1, AMARELO=0, VERMELHO=0, ESTADO=00. The yellow counter and internal timer are cleared to 0.
- Outputs are a pure decode of the state register (Moore), with no combinational path from CAR or TIMEOUT. Exactly one lamp is high in every cycle.
- Transitions, evaluated at each rising clk edge with res=1:
  - VERDE: CAR=1 -> AMARELO; otherwise stay VERDE.
  - AMARELO: hold for AMARELO_CYCLES cycles (counter starts at 0 on entry), then -> VERMELHO. CAR and TIMEOUT are ignored.
  - VERMELHO: TIMEOUT=1 -> VERDE; otherwise stay VERMELHO. CAR is ignored.
  - Illegal code 2'b11 -> VERDE on the next edge.
- Latency:
  - Lamps change one clock edge after the qualifying input is sampled high.
  - With AMARELO_CYCLES=1, yellow is visible for exactly one clock period.
- Level semantics:
  - CAR held high across several cycles causes only one VERDE->AMARELO transition per green visit.
  - TIMEOUT held high only matters while in VERMELHO. A still-high TIMEOUT on re-entering VERDE has no effect.
  - CAR high in the same cycle VERMELHO->VERDE occurs is not acted on until the following edge, where it is sampled in VERDE.
- Simultaneous CAR=1 and TIMEOUT=1: only the input relevant to the current state is used.
- Reset asserted mid-cycle (any state, including during the yellow count) forces VERDE at once. The count is discarded.

Optional Feature:
- Macro: SEMAFORO_INT_TIMER_EN.
- When defined:
  - An internal 16-bit counter clears on entry to VERMELHO and increments each cycle in VERMELHO.
  - The red exit condition is (counter == VERMELHO_CYCLES-1) OR TIMEOUT=1, so the external TIMEOUT still forces an early exit.
  - The counter is reset by res.
- When undefined:
  - No counter is generated and VERMELHO_CYCLES is unused.
  - VERMELHO exits only on TIMEOUT=1.

Test Plan:
- Reset: res=0 for 12 time units with CAR=0 and TIMEOUT=0 -> VERDE=1, AMARELO=0, VERMELHO=0, ESTADO=00 throughout, also before the first clk edge.
- Green hold and exit: res=1, CAR=0 for 3 cycles -> VERDE stays 1. CAR=1 for 1 cycle -> at the next edge AMARELO=1; one edge later VERMELHO=1 (AMARELO_CYCLES=1).
- Red hold and exit: in VERMELHO with CAR toggling and TIMEOUT=0 for 4 cycles -> VERMELHO stays 1. TIMEOUT=1 for 2 cycles -> VERDE=1 after the first edge, and it stays VERDE on the second edge.
- Ignored inputs: TIMEOUT=1 while in VERDE -> no change. CAR=1 held across a full cycle -> exactly one pass through AMARELO and a stop in VERMELHO.
- Reset mid-operation: assert res=0 asynchronously while AMARELO=1, between clock edges -> VERDE=1 immediately. After release, CAR=1 restarts the cycle normally.
- Parameter and option: AMARELO_CYCLES=3 -> AMARELO high for exactly 3 cycles. With SEMAFORO_INT_TIMER_EN and VERMELHO_CYCLES=4, TIMEOUT=0 -> VERMELHO high for exactly 4 cycles, then VERDE.
- Every test checks one-hot lamps every cycle.
